// File: rtl/dec_disp_if.sv
// Display-side bus between the counter/select logic and the scanner.
// master: produces the digit word and blink selects, consumes the drives.
// slave : the scanner itself.
interface dec_disp_if;
  logic [15:0] DEC;
  logic [3:0]  BLINK_SEL;
  logic [3:0]  AN;
  logic [6:0]  SEG;

  modport master (output DEC, output BLINK_SEL, input AN, input SEG);
  modport slave  (input DEC, input BLINK_SEL, output AN, output SEG);
endinterface

// File: rtl/dec_disp_scan.sv
// 4-digit multiplexed 7-segment scanner for the DEC[15:0] counter word.
// Digit 0 is leftmost and comes from DEC[15:12]. The word is snapshotted
// once per scan frame so a digit never tears mid-frame. Digits marked in
// BLINK_SEL blink with a half-period of BLINK_FRAMES frames.
// Optional macro DEC_DISP_LZB_EN adds leading-zero blanking of digits 0..2.
module dec_disp_scan #(
  parameter int REFRESH_DIV    = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  dec_disp_if.slave  disp
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  // Active-high hex glyph, bit0 = segment a.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Nibble of the word for digit k (digit 0 is the most significant).
  function automatic logic [3:0] digit_of(input logic [15:0] word, input logic [1:0] k);
    logic [3:0] n;
    case (k)
      2'd0:    n = word[15:12];
      2'd1:    n = word[11:8];
      2'd2:    n = word[7:4];
      default: n = word[3:0];
    endcase
    return n;
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic tick;
  logic frame_end;
  logic blank;
  logic [3:0] an_hot;
  logic [6:0] seg_hot;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign frame_end = tick && (idx_q == 2'd3);

  // Scan timing: refresh divider, digit index, frame snapshot and blink phase.
  always_comb begin
    div_cnt_d   = div_cnt_q + 1'b1;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (tick) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
    if (frame_end) begin
      shadow_d = disp.DEC;
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Output drive for the currently selected digit; registered next edge.
  always_comb begin
    blank = disp.BLINK_SEL[idx_q] && !blink_on_q;
`ifdef DEC_DISP_LZB_EN
    // A digit is a leading zero when it and every digit left of it is 0.
    case (idx_q)
      2'd0:    blank = blank || (shadow_q[15:12] == 4'h0);
      2'd1:    blank = blank || (shadow_q[15:8] == 8'h00);
      2'd2:    blank = blank || (shadow_q[15:4] == 12'h000);
      default: blank = blank;
    endcase
`endif
    seg_hot = blank ? 7'h00 : glyph(digit_of(shadow_q, idx_q));
    an_hot  = 4'b0001 << idx_q;
    an_d    = SEG_ACTIVE_LOW ? ~an_hot : an_hot;
    seg_d   = SEG_ACTIVE_LOW ? ~seg_hot : seg_hot;
  end

  // State and output registers; reset blanks the display and restarts at digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      idx_q       <= 2'd0;
      shadow_q    <= 16'h0000;
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign disp.AN  = an_q;
  assign disp.SEG = seg_q;

endmodule

// File: tb/tb_dec_disp_scan.sv
// Directed bench for dec_disp_scan. Three instances share clk/rst:
// a: REFRESH_DIV=2, BLINK_FRAMES=2, active-low
// b: same timing, active-high
// c: REFRESH_DIV=1, active-low
// After reset release, edge n (n=0 first) drives digit (n/2)%4 on a/b;
// frame f = n/8 shows the word captured at edge 8f-1.
module tb_dec_disp_scan;

  logic clk;
  logic rst;
  int checks;
  int errors;
  int ecnt;

  logic [3:0] an_lo [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  dec_disp_if if_a ();
  dec_disp_if if_b ();
  dec_disp_if if_c ();

  dec_disp_scan #(.REFRESH_DIV(2), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .disp(if_a));
  dec_disp_scan #(.REFRESH_DIV(2), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .disp(if_b));
  dec_disp_scan #(.REFRESH_DIV(1), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b1)) dut_c (
    .clk(clk), .rst(rst), .disp(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_inputs(input logic [15:0] dec, input logic [3:0] sel);
    if_a.DEC = dec; if_a.BLINK_SEL = sel;
    if_b.DEC = dec; if_b.BLINK_SEL = sel;
    if_c.DEC = dec; if_c.BLINK_SEL = sel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic apply_reset(input int ncyc);
    rst = 1'b1;
    repeat (ncyc) step();
    rst = 1'b0;
    ecnt = -1;
  endtask

  task automatic test_reset();
    set_inputs(16'h0000, 4'b0000);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_a.AN !== 4'hF || if_a.SEG !== 7'h7F) begin
        errors++;
        $display("FAIL reset_a cyc=%0d AN=%b SEG=%h expected AN=1111 SEG=7f", i, if_a.AN, if_a.SEG);
      end
      checks++;
      if (if_b.AN !== 4'h0 || if_b.SEG !== 7'h00) begin
        errors++;
        $display("FAIL reset_b cyc=%0d AN=%b SEG=%h expected AN=0000 SEG=00", i, if_b.AN, if_b.SEG);
      end
    end
    rst = 1'b0;
    ecnt = -1;
  endtask

  task automatic test_first_frame();
    int d;
    for (int n = 0; n < 8; n++) begin
      step();
      d = n / 2;
      checks++;
      if (if_a.AN !== an_lo[d]) begin
        errors++;
        $display("FAIL frame0_an n=%0d got %b expected %b", n, if_a.AN, an_lo[d]);
      end
      checks++;
      if (if_a.SEG !== 7'h40) begin
        errors++;
        $display("FAIL frame0_seg n=%0d got %h expected 40", n, if_a.SEG);
      end
      checks++;
      if (if_b.AN !== ~an_lo[d] || if_b.SEG !== 7'h3F) begin
        errors++;
        $display("FAIL frame0_b n=%0d AN=%b SEG=%h expected AN=%b SEG=3f", n, if_b.AN, if_b.SEG, ~an_lo[d]);
      end
      if (n < 4) begin
        checks++;
        if (if_c.AN !== an_lo[n] || if_c.SEG !== 7'h40) begin
          errors++;
          $display("FAIL div1_scan n=%0d AN=%b SEG=%h expected AN=%b SEG=40", n, if_c.AN, if_c.SEG, an_lo[n]);
        end
      end
      if (n == 3) set_inputs(16'h1234, 4'b0000);
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] exp_seg [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
    int d;
    for (int n = 8; n < 16; n++) begin
      step();
      d = (n / 2) % 4;
      checks++;
      if (if_a.AN !== an_lo[d] || if_a.SEG !== exp_seg[d]) begin
        errors++;
        $display("FAIL snap_1234 n=%0d AN=%b SEG=%h expected AN=%b SEG=%h", n, if_a.AN, if_a.SEG, an_lo[d], exp_seg[d]);
      end
      if (n == 10) set_inputs(16'hABCF, 4'b0000);
    end
  endtask

  task automatic test_hex_letters();
    logic [6:0] exp_lo [4] = '{7'h08, 7'h03, 7'h46, 7'h0E};
    logic [6:0] exp_hi [4] = '{7'h77, 7'h7C, 7'h39, 7'h71};
    int d;
    for (int n = 16; n < 24; n++) begin
      step();
      d = (n / 2) % 4;
      checks++;
      if (if_a.AN !== an_lo[d] || if_a.SEG !== exp_lo[d]) begin
        errors++;
        $display("FAIL hex_lo n=%0d AN=%b SEG=%h expected AN=%b SEG=%h", n, if_a.AN, if_a.SEG, an_lo[d], exp_lo[d]);
      end
      checks++;
      if (if_b.AN !== ~an_lo[d] || if_b.SEG !== exp_hi[d]) begin
        errors++;
        $display("FAIL hex_hi n=%0d AN=%b SEG=%h expected AN=%b SEG=%h", n, if_b.AN, if_b.SEG, ~an_lo[d], exp_hi[d]);
      end
    end
  endtask

  task automatic test_blink();
    int d;
    int f;
    logic [6:0] exp;
    set_inputs(16'h5555, 4'b0100);
    apply_reset(2);
    for (int n = 0; n < 48; n++) begin
      step();
      d = (n / 2) % 4;
      f = n / 8;
      if (f == 0) exp = 7'h40;
      else if (d == 2 && (f == 2 || f == 3)) exp = 7'h7F;
      else exp = 7'h12;
      checks++;
      if (if_a.AN !== an_lo[d] || if_a.SEG !== exp) begin
        errors++;
        $display("FAIL blink n=%0d AN=%b SEG=%h expected AN=%b SEG=%h", n, if_a.AN, if_a.SEG, an_lo[d], exp);
      end
    end
  endtask

  task automatic test_lzb();
`ifdef DEC_DISP_LZB_EN
    logic [6:0] exp70 [4] = '{7'h7F, 7'h7F, 7'h78, 7'h40};
    logic [6:0] exp00 [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
    logic [6:0] exp70 [4] = '{7'h40, 7'h40, 7'h78, 7'h40};
    logic [6:0] exp00 [4] = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif
    int d;
    set_inputs(16'h0070, 4'b0000);
    for (int n = 48; n < 80; n++) begin
      step();
      d = (n / 2) % 4;
      if (n >= 56 && n < 64) begin
        checks++;
        if (if_a.AN !== an_lo[d] || if_a.SEG !== exp70[d]) begin
          errors++;
          $display("FAIL lzb_0070 n=%0d AN=%b SEG=%h expected AN=%b SEG=%h", n, if_a.AN, if_a.SEG, an_lo[d], exp70[d]);
        end
      end
      if (n >= 72) begin
        checks++;
        if (if_a.AN !== an_lo[d] || if_a.SEG !== exp00[d]) begin
          errors++;
          $display("FAIL lzb_0000 n=%0d AN=%b SEG=%h expected AN=%b SEG=%h", n, if_a.AN, if_a.SEG, an_lo[d], exp00[d]);
        end
      end
      if (n == 63) set_inputs(16'h0000, 4'b0000);
    end
  endtask

  task automatic test_rst_midframe();
    int d;
    logic [6:0] exp;
    set_inputs(16'h9999, 4'b0000);
    for (int n = 80; n < 92; n++) begin
      step();
      if (n == 88) begin
        checks++;
        if (if_a.AN !== 4'b1110 || if_a.SEG !== 7'h10) begin
          errors++;
          $display("FAIL pre_rst_9999 AN=%b SEG=%h expected AN=1110 SEG=10", if_a.AN, if_a.SEG);
        end
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (if_a.AN !== 4'hF || if_a.SEG !== 7'h7F) begin
      errors++;
      $display("FAIL rst_pulse_out AN=%b SEG=%h expected AN=1111 SEG=7f", if_a.AN, if_a.SEG);
    end
    checks++;
    if (dut_a.idx_q !== 2'd0 || dut_a.shadow_q !== 16'h0000) begin
      errors++;
      $display("FAIL rst_pulse_state idx=%0d shadow=%h expected idx=0 shadow=0000", dut_a.idx_q, dut_a.shadow_q);
    end
    rst = 1'b0;
    ecnt = -1;
    for (int n = 0; n < 16; n++) begin
      step();
      d = (n / 2) % 4;
      exp = (n < 8) ? 7'h40 : 7'h10;
      checks++;
      if (if_a.AN !== an_lo[d] || if_a.SEG !== exp) begin
        errors++;
        $display("FAIL post_rst n=%0d AN=%b SEG=%h expected AN=%b SEG=%h", n, if_a.AN, if_a.SEG, an_lo[d], exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ecnt = 0;
    rst = 1'b1;
    set_inputs(16'h0000, 4'b0000);
    test_reset();
    test_first_frame();
    test_snapshot();
    test_hex_letters();
    test_blink();
    test_lzb();
    test_rst_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_disp_scan.md
Name: dec_disp_scan

Overview:
- Downstream consumer of the 4-digit up/down counter bus DEC[15:0]; drives a 4-digit multiplexed 7-segment display.
- Time-multiplexes the digits at a programmable refresh rate and decodes each nibble to a hex glyph.
- Snapshots DEC once per scan frame so a digit never tears mid-frame.
- Blinks the digits currently selected for editing, using the same one-hot selects that drive the counter enables.

Parameters:
REFRESH_DIV, 1000, clk cycles each digit stays lit (>=1)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)
SEG_ACTIVE_LOW, 1, 1: SEG and AN are active-low; 0: active-high

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
DEC  input  16  digit k = DEC[15-4k:12-4k]; digit 0 is most significant/leftmost
BLINK_SEL  input  4  bit k=1 marks digit k for blinking (same one-hot as st0..st3)
AN  output  4  digit enables; AN[k] lights digit k
SEG  output  7  segments {g,f,e,d,c,b,a}

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - AN = all inactive, SEG = all inactive.
  - div_cnt=0, idx=0, shadow=16'h0000, frame_cnt=0, blink_on=1 (visible).
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1; tick=1 when div_cnt==REFRESH_DIV-1, then div_cnt wraps to 0.
  - With REFRESH_DIV=1, tick is asserted every cycle.
- Digit index: on tick, idx <= idx+1 mod 4 (0,1,2,3,0...).
- Frame boundary: a tick with idx==3.
  - Same edge: shadow <= DEC.
  - frame_cnt increments. When frame_cnt==BLINK_FRAMES-1, frame_cnt wraps to 0 and blink_on toggles.
- Outputs are registered each cycle from the current state:
  - AN: only bit idx active.
  - SEG: glyph(shadow digit idx), or blank.
  - Latency: 1 cycle from an idx change to AN/SEG change. Exactly one AN bit is active at all times after the first post-reset edge.
- Glyphs (active-high hex, bit0=a):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - All 16 codes are legal; the upstream counter wraps through 10-15.
  - SEG_ACTIVE_LOW=1 inverts both SEG and AN.
- Blank means all segments inactive while the digit's AN is still driven active. A digit is blank when BLINK_SEL[idx]==1 and blink_on==0.
- BLINK_SEL is not shadowed; a change takes effect on the next output register update.
- DEC changes mid-frame are invisible until the next frame boundary. Worst-case visibility latency is 4*REFRESH_DIV+1 cycles.
- DEC changing on the boundary edge itself: the value present at that edge is captured.
- rst mid-frame: all state returns to reset values on the next edge. AN/SEG go inactive for that cycle; the scan restarts at digit 0.

Optional Feature:
- Macro: DEC_DISP_LZB_EN (leading-zero blanking).
- Defined: digit k (k=0..2) is blank when shadow digits 0..k are all 4'h0. Digit 3 is never blanked this way, so 0000 shows "   0". Blink blanking is ORed with this blanking.
- Undefined: no leading-zero logic is generated; all digits are always decoded.

Test Plan:
- REFRESH_DIV=2, rst held 3 cycles then released:
  - AN inactive and SEG=7'h7F (inactive, active-low) during reset.
  - After release, AN cycles 4'b1110,1101,1011,0111 with each value held 2 cycles; SEG=~3F (digit "0") throughout the first frame.
- DEC=16'h1234 applied mid first frame:
  - The first frame still shows 0000.
  - The second frame shows SEG=~06,~5B,~4F,~66 on AN 1110,1101,1011,0111.
- DEC=16'hAbCF:
  - SEG=~77,~7C,~39,~71.
  - With SEG_ACTIVE_LOW=0: SEG=77,7C,39,71 and AN one-hot active-high.
- BLINK_FRAMES=2, BLINK_SEL=4'b0100, DEC=16'h5555:
  - Digit 2 shows ~6D for 2 frames, blank (7F) for 2 frames, repeating.
  - Other digits always show ~6D.
- DEC_DISP_LZB_EN defined, DEC=16'h0070:
  - Digits 0 and 1 are blank; digits 2 and 3 show "7" and "0".
  - DEC=16'h0000 shows only digit 3 as "0".
  - Without the macro, 16'h0070 shows "0070".
- rst pulsed 1 cycle while idx==2 with DEC=16'h9999:
  - The next cycle has AN inactive, idx=0, shadow=0.
  - "0000" is shown until the first frame boundary, then "9999".
